// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder: oversamples SCLK/CS/DI, decodes CMD0/CMD8/CMD55/ACMD41, returns R1/R7.
// Optional frame CRC7 checking is enabled by defining SD_RESP_CRC_CHECK_EN.
module sd_spi_card_responder #(
   parameter int NCR_BYTES    = 1,
   parameter int INIT_RETRIES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SCLK,
   input  logic        CS,
   input  logic        DI,
   output logic        DO,
   output logic        cmdValid,
   output logic [5:0]  cmdIndex,
   output logic [31:0] cmdArg,
   output logic        cardReady
);

   typedef enum logic [2:0] {S_IDLE, S_HUNT, S_RX, S_NCR, S_TX} state_t;

   localparam logic [6:0] LP_NCR_FALLS = 7'(NCR_BYTES * 8);
   localparam logic [7:0] LP_RETRIES   = 8'(INIT_RETRIES);

   state_t      r_state;
   logic [2:0]  r_sclk_sync;
   logic [1:0]  r_cs_sync;
   logic [1:0]  r_di_sync;
   logic [46:0] r_shift;
   logic [5:0]  r_bit_cnt;
   logic [6:0]  r_ncr_cnt;
   logic [5:0]  r_tx_cnt;
   logic [5:0]  r_resp_len;
   logic [39:0] r_resp;
   logic        r_do;
   logic        r_cmd_valid;
   logic [5:0]  r_cmd_index;
   logic [31:0] r_cmd_arg;
   logic        r_card_ready;
   logic        r_idle;
   logic        r_app_cmd;
   logic [7:0]  r_acmd_cnt;

   logic        w_rise;
   logic        w_fall;
   logic        w_cs;
   logic        w_di;
   logic [47:0] w_frame;
   logic        w_idle_nx;
   logic        w_app_nx;
   logic [7:0]  w_acnt_nx;
   logic        w_ready_nx;
   logic [7:0]  w_r1;
   logic [5:0]  w_resp_len;
   logic [39:0] w_resp;

   assign DO        = r_do;
   assign cmdValid  = r_cmd_valid;
   assign cmdIndex  = r_cmd_index;
   assign cmdArg    = r_cmd_arg;
   assign cardReady = r_card_ready;

   // Synchronizers carry no reset so a reset can never fabricate an SCLK edge.
   always_ff @(posedge clk) begin
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_cs_sync   <= {r_cs_sync[0], CS};
      r_di_sync   <= {r_di_sync[0], DI};
   end

   assign w_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_fall  = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign w_cs    = r_cs_sync[1];
   assign w_di    = r_di_sync[1];
   assign w_frame = {r_shift, w_di};

`ifdef SD_RESP_CRC_CHECK_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction
`else
   logic w_unused_bits;
   assign w_unused_bits = &{w_frame[47], w_frame[7:1]};
`endif

   always_comb begin
      w_idle_nx  = r_idle;
      w_app_nx   = 1'b0;
      w_acnt_nx  = r_acmd_cnt;
      w_ready_nx = r_card_ready;
      w_r1       = {5'b0, 1'b1, 1'b0, r_idle};
      w_resp_len = 6'd8;
      case (w_frame[45:40])
         6'd0: begin
            w_idle_nx  = 1'b1;
            w_acnt_nx  = 8'd0;
            w_ready_nx = 1'b0;
            w_r1       = 8'h01;
         end
         6'd8: begin
            w_r1       = {7'b0, r_idle};
            w_resp_len = 6'd40;
         end
         6'd55: begin
            w_app_nx = 1'b1;
            w_r1     = {7'b0, r_idle};
         end
         6'd41: if (r_app_cmd) begin
            w_r1 = 8'h00;
            if (r_idle) begin
               if (r_acmd_cnt != 8'hFF) w_acnt_nx = r_acmd_cnt + 8'd1;
               if (r_acmd_cnt < LP_RETRIES) w_r1 = 8'h01;
               else begin
                  w_idle_nx  = 1'b0;
                  w_ready_nx = 1'b1;
               end
            end
         end
         default: ;
      endcase
      w_resp = (w_resp_len == 6'd40) ? {w_r1, 20'h00000, w_frame[19:8]} : {w_r1, 32'h0};
`ifdef SD_RESP_CRC_CHECK_EN
      if (crc7(w_frame[47:8]) != w_frame[7:1]) begin
         w_idle_nx  = r_idle;
         w_app_nx   = r_app_cmd;
         w_acnt_nx  = r_acmd_cnt;
         w_ready_nx = r_card_ready;
         w_resp_len = 6'd8;
         w_resp     = {4'b0000, 1'b1, 2'b00, r_idle, 32'h0};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_do         <= 1'b1;
         r_cmd_valid  <= 1'b0;
         r_cmd_index  <= 6'd0;
         r_cmd_arg    <= 32'd0;
         r_card_ready <= 1'b0;
         r_idle       <= 1'b1;
         r_app_cmd    <= 1'b0;
         r_acmd_cnt   <= 8'd0;
      end else begin
         r_cmd_valid <= 1'b0;
         if (w_cs) begin
            r_state <= S_IDLE;
            r_do    <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_HUNT;
               S_HUNT: if (w_rise && !w_di) begin
                  r_shift   <= 47'd0;
                  r_bit_cnt <= 6'd1;
                  r_state   <= S_RX;
               end
               S_RX: if (w_rise) begin
                  r_shift   <= w_frame[46:0];
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == 6'd47) begin
                     if (w_frame[46] && w_frame[0]) begin
                        r_cmd_valid  <= 1'b1;
                        r_cmd_index  <= w_frame[45:40];
                        r_cmd_arg    <= w_frame[39:8];
                        r_idle       <= w_idle_nx;
                        r_app_cmd    <= w_app_nx;
                        r_acmd_cnt   <= w_acnt_nx;
                        r_card_ready <= w_ready_nx;
                        r_resp       <= w_resp;
                        r_resp_len   <= w_resp_len;
                        r_ncr_cnt    <= 7'd0;
                        r_tx_cnt     <= 6'd0;
                        r_state      <= S_NCR;
                     end else begin
                        r_state <= S_HUNT;
                     end
                  end
               end
               S_NCR: if (w_fall) begin
                  r_do      <= 1'b1;
                  r_ncr_cnt <= r_ncr_cnt + 7'd1;
                  if (r_ncr_cnt == LP_NCR_FALLS - 7'd1) r_state <= S_TX;
               end
               S_TX: if (w_fall) begin
                  if (r_tx_cnt == r_resp_len) begin
                     r_do    <= 1'b1;
                     r_state <= S_HUNT;
                  end else begin
                     r_do     <= r_resp[39];
                     r_resp   <= {r_resp[38:0], 1'b1};
                     r_tx_cnt <= r_tx_cnt + 6'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
